program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Host-facing run controller for the single-cycle core. Accepts a four-phase req/ack request
//  from the test host and selects one of NUM_PROGS programs by prog_sel. Drives the program
//  counter's start pulse, starting address and done address, then waits for core_done.
//  Reports elapsed run cycles, a watchdog timeout and an invalid-select error.
//  It sits between the testbench/host and programcounter, replacing the fixed address constants.
// PARAMETERS
//  PC_BITS      9     width of program-counter addresses
//  CNT_BITS     16    width of run-cycle counter
//  NUM_PROGS    3     number of valid programs (prog_sel 0..NUM_PROGS-1)
//  START_HOLD   2     cycles start is held high in LOAD (>=1)
//  MAX_CYCLES   60000 watchdog limit on RUN cycles (< 2**CNT_BITS)
//  P0_START/P0_DONE  0/145    program 0 start and done addresses
//  P1_START/P1_DONE  146/290  program 1
//  P2_START/P2_DONE  291/435  program 2
// PORTS
//  clock             in   1         rising-edge clock
//  reset_n           in   1         asynchronous active-low reset
//  req               in   1         host request, level; held until ack seen
//  prog_sel          in   2         program index, sampled in IDLE when req=1
//  core_done         in   1         done from programcounter
//  start             out  1         start to programcounter
//  starting_address  out  PC_BITS   start address to programcounter
//  done_address      out  PC_BITS   done address to programcounter
//  ack               out  1         run complete; held until req falls
//  busy              out  1         1 in LOAD or RUN
//  timeout           out  1         last run hit MAX_CYCLES
//  bad_sel           out  1         last request had prog_sel >= NUM_PROGS
//  cycle_count       out  CNT_BITS  RUN cycles of last/current run
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE. start, ack, busy, timeout and bad_sel are 0.
//   cycle_count=0. Addresses = P0_START/P0_DONE. Reset mid-run aborts immediately.
//  All outputs are registered. There is no combinational path from inputs to outputs.
//  State machine: IDLE -> LOAD -> RUN -> ACK -> IDLE.
//  IDLE: on req=1 latch prog_sel into sel_q, then act on the latched value:
//   - sel valid: load addresses from table[sel_q]; clear timeout, bad_sel and cycle_count;
//     set start=1 and busy=1; go to LOAD (start rises on the next edge).
//   - sel invalid: set bad_sel=1 and ack=1; go to ACK. start is never asserted;
//     addresses are unchanged.
//  LOAD: start=1 for exactly START_HOLD cycles, counted by the hold counter.
//   core_done is ignored in LOAD because it may be stale from the previous run.
//   After the last hold cycle: start=0; go to RUN.
//  RUN: cycle_count increments by 1 every cycle, including the cycle done is seen.
//   - core_done=1: set ack=1 and busy=0; go to ACK.
//   - cycle_count reaches MAX_CYCLES first: set timeout=1, ack=1 and busy=0; go to ACK.
//   - Both in the same cycle: core_done wins and timeout stays 0.
//  ACK: ack=1 until req=0 is sampled; then ack=0 and go to IDLE.
//   A new request needs req to fall and rise again; req held high never auto-restarts.
//  req dropping during LOAD or RUN is ignored; the run completes and ack is still raised.
//  prog_sel changes after the IDLE sample are ignored, since sel_q is held.
//  cycle_count, timeout, bad_sel and the addresses hold their values through ACK and IDLE
//   until the next valid request.
//  cycle_count never wraps; MAX_CYCLES < 2**CNT_BITS is checked by elaboration assert.
//  Latency, req rise to start rise: 1 cycle. core_done to ack: 1 cycle.
// TESTING
//  1. Hold reset_n=0 with req=1 -> all outputs at reset values; no start pulse.
//  2. req=1, sel=1; core_done 10 cycles after start falls -> start high 2 cycles,
//     addresses 146/290, ack 1 cycle after done, cycle_count=11.
//  3. sel=3 -> bad_sel=1, ack=1 next cycle, start never high; drop req -> ack=0 next cycle.
//  4. MAX_CYCLES=20, core_done never asserted -> timeout=1, ack=1, cycle_count=20, busy=0.
//  5. core_done held high from the previous run through LOAD -> ignored until RUN; then
//     ack after the first RUN cycle with cycle_count=1.
//  6. Pull reset_n low 5 cycles into RUN -> start, busy and ack go 0 immediately; state IDLE;
//     the next req=1 starts a fresh run.

Source files
------------

// File: rtl/program_sequencer.sv
// Host-facing run controller: four-phase req/ack handshake, program select, start pulse to the
// program counter, run-cycle counting with watchdog. All outputs come straight from flops.
module program_sequencer #(
  parameter int unsigned PC_BITS    = 9,
  parameter int unsigned CNT_BITS   = 16,
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned START_HOLD = 2,
  parameter int unsigned MAX_CYCLES = 60000,
  parameter int unsigned P0_START   = 0,
  parameter int unsigned P0_DONE    = 145,
  parameter int unsigned P1_START   = 146,
  parameter int unsigned P1_DONE    = 290,
  parameter int unsigned P2_START   = 291,
  parameter int unsigned P2_DONE    = 435
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req,
  input  logic [1:0]          prog_sel,
  input  logic                core_done,
  output logic                start,
  output logic [PC_BITS-1:0]  starting_address,
  output logic [PC_BITS-1:0]  done_address,
  output logic                ack,
  output logic                busy,
  output logic                timeout,
  output logic                bad_sel,
  output logic [CNT_BITS-1:0] cycle_count
);

  if (MAX_CYCLES >= (64'd1 << CNT_BITS) || START_HOLD < 1) begin : g_bad_params
    $error("program_sequencer: MAX_CYCLES must fit in CNT_BITS and START_HOLD must be >= 1");
  end

  localparam int unsigned HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ACK} state_e;

  state_e              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                start_q, start_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic                bad_sel_q, bad_sel_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [PC_BITS-1:0]  sa_q, sa_d;
  logic [PC_BITS-1:0]  da_q, da_d;
  logic [CNT_BITS-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_BITS'(1);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    start_d   = start_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    timeout_d = timeout_q;
    bad_sel_d = bad_sel_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    da_d      = da_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (32'(prog_sel) < NUM_PROGS) begin
            case (prog_sel)
              2'd0: begin sa_d = PC_BITS'(P0_START); da_d = PC_BITS'(P0_DONE); end
              2'd1: begin sa_d = PC_BITS'(P1_START); da_d = PC_BITS'(P1_DONE); end
              default: begin sa_d = PC_BITS'(P2_START); da_d = PC_BITS'(P2_DONE); end
            endcase
            timeout_d = 1'b0;
            bad_sel_d = 1'b0;
            cnt_d     = '0;
            start_d   = 1'b1;
            busy_d    = 1'b1;
            hold_d    = '0;
            state_d   = S_LOAD;
          end else begin
            bad_sel_d = 1'b1;
            ack_d     = 1'b1;
            state_d   = S_ACK;
          end
        end
      end
      // core_done is deliberately not looked at here: it may still be high from the last run.
      S_LOAD: begin
        if (hold_q == HOLD_LAST) begin
          start_d = 1'b0;
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (core_done) begin
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_ACK;
        end else if (cnt_inc == CNT_MAX) begin
          timeout_d = 1'b1;
          ack_d     = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      bad_sel_q <= 1'b0;
      cnt_q     <= '0;
      sa_q      <= PC_BITS'(P0_START);
      da_q      <= PC_BITS'(P0_DONE);
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      bad_sel_q <= bad_sel_d;
      cnt_q     <= cnt_d;
      sa_q      <= sa_d;
      da_q      <= da_d;
    end
  end

  assign start            = start_q;
  assign ack              = ack_q;
  assign busy             = busy_q;
  assign timeout          = timeout_q;
  assign bad_sel          = bad_sel_q;
  assign cycle_count      = cnt_q;
  assign starting_address = sa_q;
  assign done_address     = da_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a shortened watchdog (MAX_CYCLES=20).
module tb_program_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req;
  logic [1:0]  prog_sel;
  logic        core_done;
  logic        start;
  logic [8:0]  starting_address;
  logic [8:0]  done_address;
  logic        ack;
  logic        busy;
  logic        timeout;
  logic        bad_sel;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  program_sequencer #(.MAX_CYCLES(20)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req(req),
    .prog_sel(prog_sel),
    .core_done(core_done),
    .start(start),
    .starting_address(starting_address),
    .done_address(done_address),
    .ack(ack),
    .busy(busy),
    .timeout(timeout),
    .bad_sel(bad_sel),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b1; prog_sel = 2'd1; core_done = 1'b0;
    step(3);
    check("rst_start", 32'(start), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_bad_sel", 32'(bad_sel), 0);
    check("rst_count", 32'(cycle_count), 0);
    check("rst_saddr", 32'(starting_address), 0);
    check("rst_daddr", 32'(done_address), 145);

    // Normal run of program 1
    reset_n = 1'b1;
    step(1);
    check("p1_start_c1", 32'(start), 1);
    check("p1_busy", 32'(busy), 1);
    check("p1_saddr", 32'(starting_address), 146);
    check("p1_daddr", 32'(done_address), 290);
    step(1);
    check("p1_start_c2", 32'(start), 1);
    step(1);
    check("p1_start_fall", 32'(start), 0);
    check("p1_busy_run", 32'(busy), 1);
    prog_sel = 2'd2;
    step(10);
    check("p1_count_10", 32'(cycle_count), 10);
    check("p1_no_ack_yet", 32'(ack), 0);
    core_done = 1'b1;
    step(1);
    check("p1_ack", 32'(ack), 1);
    check("p1_busy_done", 32'(busy), 0);
    check("p1_count", 32'(cycle_count), 11);
    check("p1_saddr_held", 32'(starting_address), 146);
    step(2);
    check("p1_ack_held", 32'(ack), 1);
    check("p1_no_restart", 32'(start), 0);
    req = 1'b0;
    step(1);
    check("p1_ack_drop", 32'(ack), 0);
    check("p1_count_held", 32'(cycle_count), 11);

    // Stale core_done through LOAD, program 0
    req = 1'b1; prog_sel = 2'd0;
    step(1);
    check("st_start_c1", 32'(start), 1);
    check("st_saddr", 32'(starting_address), 0);
    check("st_daddr", 32'(done_address), 145);
    check("st_count_clr", 32'(cycle_count), 0);
    step(1);
    check("st_start_c2", 32'(start), 1);
    check("st_ignored_load", 32'(ack), 0);
    step(1);
    check("st_start_fall", 32'(start), 0);
    check("st_no_ack_run0", 32'(ack), 0);
    step(1);
    check("st_ack", 32'(ack), 1);
    check("st_count", 32'(cycle_count), 1);
    check("st_busy", 32'(busy), 0);
    req = 1'b0; core_done = 1'b0;
    step(1);
    check("st_ack_drop", 32'(ack), 0);

    // Invalid select
    req = 1'b1; prog_sel = 2'd3;
    step(1);
    check("bs_bad_sel", 32'(bad_sel), 1);
    check("bs_ack", 32'(ack), 1);
    check("bs_start", 32'(start), 0);
    check("bs_busy", 32'(busy), 0);
    check("bs_saddr_kept", 32'(starting_address), 0);
    check("bs_count_kept", 32'(cycle_count), 1);
    step(1);
    check("bs_start_still0", 32'(start), 0);
    req = 1'b0;
    step(1);
    check("bs_ack_drop", 32'(ack), 0);
    check("bs_bad_sel_held", 32'(bad_sel), 1);

    // Watchdog, program 2
    req = 1'b1; prog_sel = 2'd2;
    step(1);
    check("wd_bad_sel_clr", 32'(bad_sel), 0);
    check("wd_start", 32'(start), 1);
    check("wd_saddr", 32'(starting_address), 291);
    check("wd_daddr", 32'(done_address), 435);
    step(2);
    check("wd_start_fall", 32'(start), 0);
    step(19);
    check("wd_count_19", 32'(cycle_count), 19);
    check("wd_no_timeout_yet", 32'(timeout), 0);
    check("wd_no_ack_yet", 32'(ack), 0);
    step(1);
    check("wd_timeout", 32'(timeout), 1);
    check("wd_ack", 32'(ack), 1);
    check("wd_count", 32'(cycle_count), 20);
    check("wd_busy", 32'(busy), 0);
    req = 1'b0;
    step(1);
    check("wd_ack_drop", 32'(ack), 0);
    check("wd_timeout_held", 32'(timeout), 1);
    check("wd_count_held", 32'(cycle_count), 20);

    // Reset mid-run
    req = 1'b1; prog_sel = 2'd1;
    step(1);
    check("mr_timeout_clr", 32'(timeout), 0);
    check("mr_start", 32'(start), 1);
    step(2);
    step(5);
    check("mr_count_5", 32'(cycle_count), 5);
    check("mr_busy_run", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_busy_rst", 32'(busy), 0);
    check("mr_start_rst", 32'(start), 0);
    check("mr_ack_rst", 32'(ack), 0);
    check("mr_count_rst", 32'(cycle_count), 0);
    check("mr_saddr_rst", 32'(starting_address), 0);
    step(1);
    reset_n = 1'b1;
    step(1);
    check("mr_restart", 32'(start), 1);
    check("mr_restart_busy", 32'(busy), 1);
    check("mr_restart_saddr", 32'(starting_address), 146);
    req = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
